// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central stall/flush controller for a 5-stage pipeline. Gathers the wait and
// hazard indications from fetch, decode, execute and memory and produces the
// per-register hold (stall_*) and bubble-insert (reset_*) controls, plus the
// PC hold and redirect.
//
// A taken branch that arrives while a fetch is still in flight is parked in
// pend_pc (state REDIR_PEND). The redirect is issued once the fetch returns,
// and the stale instruction is squashed in that same cycle.
//
// Optional feature macro: PIPE_CTRL_PERF_EN
//   When defined, four saturating CNT_W-bit performance counters are added as
//   extra output ports. When undefined, neither the ports nor the counters
//   exist.
//
// Ports:
//   clk             in   clock
//   reset           in   asynchronous reset, active-low
//   Iwait           in   fetch memory access outstanding
//   Dwait           in   data memory access outstanding in MEM
//   exe_is_waiting  in   multi-cycle mul/div busy in EX
//   load_use        in   ID instruction needs a load result currently in EX
//   branch_taken    in   EX resolved a taken branch/jump this cycle
//   branch_target   in   [PC_W-1:0] target for branch_taken
//   stall_pc        out  PC register holds
//   stall_IF_ID     out  IF/ID holds
//   stall_ID_EX     out  ID/EX reloads its previous contents
//   stall_EX_MEM    out  EX/MEM holds
//   stall_MEM_WB    out  MEM/WB holds
//   reset_IF_ID     out  1 (RESET_RESET) inserts a bubble, 0 = continue
//   reset_ID_EX     out  same, for ID/EX
//   reset_EX_MEM    out  same, for EX/MEM
//   redirect_valid  out  PC loads redirect_pc this cycle
//   redirect_pc     out  [PC_W-1:0] redirect target (0 when not redirecting)
//   redir_pending   out  controller is in REDIR_PEND
//   perf_*          out  [CNT_W-1:0] perf counters (PIPE_CTRL_PERF_EN only)
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
   parameter int PC_W  = 64,
   parameter int CNT_W = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            Iwait,
   input  logic            Dwait,
   input  logic            exe_is_waiting,
   input  logic            load_use,
   input  logic            branch_taken,
   input  logic [PC_W-1:0] branch_target,
   output logic            stall_pc,
   output logic            stall_IF_ID,
   output logic            stall_ID_EX,
   output logic            stall_EX_MEM,
   output logic            stall_MEM_WB,
   output logic            reset_IF_ID,
   output logic            reset_ID_EX,
   output logic            reset_EX_MEM,
   output logic            redirect_valid,
   output logic [PC_W-1:0] redirect_pc,
   output logic            redir_pending
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [CNT_W-1:0] perf_dwait_cyc,
   output logic [CNT_W-1:0] perf_exe_cyc,
   output logic [CNT_W-1:0] perf_loaduse_cyc,
   output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

   // reset_t encoding for the pipeline-register reset controls
   localparam logic RESET_CONTINUE = 1'b0;
   localparam logic RESET_RESET    = 1'b1;

   typedef enum logic {
      RUN,
      REDIR_PEND
   } state_t;

   state_t            state;
   logic [PC_W-1:0]   pend_pc;

   logic              accept_pend;
   logic              release_redir;
   logic              rst_if_id_raw;
   logic              rst_id_ex_raw;
   logic              rst_ex_mem_raw;

   // Priority decode. Everything here is 0-cycle combinational from the
   // current state and inputs. While reset is asserted all controls sit at
   // their idle values, regardless of what the pipeline is presenting.
   // Dwait and exe_is_waiting apply in both states. A pending redirect is also
   // held back by exe_is_waiting, because that rule freezes the PC.
   always_comb begin
      stall_pc       = 1'b0;
      stall_IF_ID    = 1'b0;
      stall_ID_EX    = 1'b0;
      stall_EX_MEM   = 1'b0;
      stall_MEM_WB   = 1'b0;
      rst_if_id_raw  = RESET_CONTINUE;
      rst_id_ex_raw  = RESET_CONTINUE;
      rst_ex_mem_raw = RESET_CONTINUE;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      accept_pend    = 1'b0;
      release_redir  = 1'b0;

      if (reset) begin
         if (Dwait) begin
            stall_pc     = 1'b1;
            stall_IF_ID  = 1'b1;
            stall_ID_EX  = 1'b1;
            stall_EX_MEM = 1'b1;
            stall_MEM_WB = 1'b1;
         end else if (exe_is_waiting) begin
            stall_pc       = 1'b1;
            stall_IF_ID    = 1'b1;
            stall_ID_EX    = 1'b1;
            rst_ex_mem_raw = RESET_RESET;
         end else if (state == REDIR_PEND) begin
            rst_if_id_raw = RESET_RESET;
            if (Iwait) begin
               stall_pc = 1'b1;
            end else begin
               redirect_valid = 1'b1;
               redirect_pc    = pend_pc;
               release_redir  = 1'b1;
            end
         end else if (branch_taken) begin
            rst_if_id_raw = RESET_RESET;
            rst_id_ex_raw = RESET_RESET;
            if (Iwait) begin
               stall_pc    = 1'b1;
               accept_pend = 1'b1;
            end else begin
               redirect_valid = 1'b1;
               redirect_pc    = branch_target;
            end
         end else if (load_use) begin
            stall_pc      = 1'b1;
            stall_IF_ID   = 1'b1;
            rst_id_ex_raw = RESET_RESET;
         end else if (Iwait) begin
            stall_pc      = 1'b1;
            rst_if_id_raw = RESET_RESET;
         end
      end
   end

   // A held register must keep its contents, so a stall always overrides a
   // bubble request on the same register.
   always_comb begin
      reset_IF_ID   = stall_IF_ID  ? RESET_CONTINUE : rst_if_id_raw;
      reset_ID_EX   = stall_ID_EX  ? RESET_CONTINUE : rst_id_ex_raw;
      reset_EX_MEM  = stall_EX_MEM ? RESET_CONTINUE : rst_ex_mem_raw;
      redir_pending = (state == REDIR_PEND);
   end

   // Redirect FSM and the parked branch target. Asserting reset drops any
   // pending redirect immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= RUN;
         pend_pc <= '0;
      end else begin
         if (accept_pend) begin
            state   <= REDIR_PEND;
            pend_pc <= branch_target;
         end else if (release_redir) begin
            state <= RUN;
         end
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic ev_dwait;
   logic ev_exe;
   logic ev_loaduse;
   logic ev_flush;

   // Perf events mirror which priority rule won this cycle. A flush is an
   // accepted taken branch, whether it redirects now or is parked.
   always_comb begin
      ev_dwait   = reset && Dwait;
      ev_exe     = reset && !Dwait && exe_is_waiting;
      ev_flush   = reset && !Dwait && !exe_is_waiting && (state == RUN) && branch_taken;
      ev_loaduse = reset && !Dwait && !exe_is_waiting && (state == RUN) && !branch_taken && load_use;
   end

   // Saturating counters: once all-ones they stay there until reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_dwait_cyc   <= '0;
         perf_exe_cyc     <= '0;
         perf_loaduse_cyc <= '0;
         perf_flush_cnt   <= '0;
      end else begin
         if (ev_dwait && (perf_dwait_cyc != '1))
            perf_dwait_cyc <= perf_dwait_cyc + 1'b1;
         if (ev_exe && (perf_exe_cyc != '1))
            perf_exe_cyc <= perf_exe_cyc + 1'b1;
         if (ev_loaduse && (perf_loaduse_cyc != '1))
            perf_loaduse_cyc <= perf_loaduse_cyc + 1'b1;
         if (ev_flush && (perf_flush_cnt != '1))
            perf_flush_cnt <= perf_flush_cnt + 1'b1;
      end
   end
`else
   // Counter width only matters for the perf build; this empty check keeps
   // the parameter referenced so both builds share one interface.
   if (CNT_W > 0) begin : g_cnt_w_ok
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Self-checking bench for pipe_hazard_ctrl (default build, perf disabled).
// A behavioural model tracks "is a redirect parked, and where to" and derives
// the expected controls from the priority rules each cycle. Directed
// sequences with hand-computed literals pin the model, then randomized
// traffic (including random reset pulses) is checked every cycle.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        Iwait;
   logic        Dwait;
   logic        exe_is_waiting;
   logic        load_use;
   logic        branch_taken;
   logic [63:0] branch_target;
   logic        stall_pc;
   logic        stall_IF_ID;
   logic        stall_ID_EX;
   logic        stall_EX_MEM;
   logic        stall_MEM_WB;
   logic        reset_IF_ID;
   logic        reset_ID_EX;
   logic        reset_EX_MEM;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        redir_pending;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   pipe_hazard_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .Iwait          (Iwait),
      .Dwait          (Dwait),
      .exe_is_waiting (exe_is_waiting),
      .load_use       (load_use),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .stall_pc       (stall_pc),
      .stall_IF_ID    (stall_IF_ID),
      .stall_ID_EX    (stall_ID_EX),
      .stall_EX_MEM   (stall_EX_MEM),
      .stall_MEM_WB   (stall_MEM_WB),
      .reset_IF_ID    (reset_IF_ID),
      .reset_ID_EX    (reset_ID_EX),
      .reset_EX_MEM   (reset_EX_MEM),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .redir_pending  (redir_pending)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("[TB] FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
   endtask

   // Inputs change 2 time units after the rising edge.
   task automatic applyStimulus(input logic iw, input logic dw, input logic ex,
                                input logic lu, input logic bt, input logic [63:0] tgt);
      @(posedge clk);
      #2;
      Iwait          = iw;
      Dwait          = dw;
      exe_is_waiting = ex;
      load_use       = lu;
      branch_taken   = bt;
      branch_target  = tgt;
   endtask

   // ------------------------------------------------------------------
   // Behavioural model: one bit for "redirect parked" plus its target.
   // Expected controls are bundled as
   //   {stall pc,IF_ID,ID_EX,EX_MEM,MEM_WB, reset IF_ID,ID_EX,EX_MEM,
   //    redirect_valid, redir_pending}
   // ------------------------------------------------------------------
   bit          m_parked   = 1'b0;
   logic [63:0] m_park_tgt = '0;
   logic [4:0]  e_stall;
   logic [2:0]  e_rst;
   logic        e_rv;
   logic [63:0] e_pc;
   logic        e_pend;
   bit          n_parked;
   logic [63:0] n_park_tgt;

   always @(negedge clk) begin
      cyc++;
      e_stall    = 5'b00000;
      e_rst      = 3'b000;
      e_rv       = 1'b0;
      e_pc       = 64'd0;
      e_pend     = 1'b0;
      n_parked   = m_parked;
      n_park_tgt = m_park_tgt;
      if (!reset) begin
         n_parked   = 1'b0;
         n_park_tgt = 64'd0;
      end else begin
         e_pend = m_parked;
         if (Dwait) begin
            e_stall = 5'b11111;
         end else if (exe_is_waiting) begin
            e_stall = 5'b11100;
            e_rst   = 3'b001;
         end else if (m_parked) begin
            if (Iwait) begin
               e_stall = 5'b10000;
               e_rst   = 3'b100;
            end else begin
               e_rst    = 3'b100;
               e_rv     = 1'b1;
               e_pc     = m_park_tgt;
               n_parked = 1'b0;
            end
         end else if (branch_taken) begin
            e_rst = 3'b110;
            if (Iwait) begin
               e_stall    = 5'b10000;
               n_parked   = 1'b1;
               n_park_tgt = branch_target;
            end else begin
               e_rv = 1'b1;
               e_pc = branch_target;
            end
         end else if (load_use) begin
            e_stall = 5'b11000;
            e_rst   = 3'b010;
         end else if (Iwait) begin
            e_stall = 5'b10000;
            e_rst   = 3'b100;
         end
      end
      checkOutput("model_ctrl",
                  {54'd0, stall_pc, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB,
                   reset_IF_ID, reset_ID_EX, reset_EX_MEM, redirect_valid, redir_pending},
                  {54'd0, e_stall, e_rst, e_rv, e_pend});
      checkOutput("model_redirect_pc", redirect_pc, e_pc);
      m_parked   = n_parked;
      m_park_tgt = n_park_tgt;
   end

   // ------------------------------------------------------------------
   // Stimulus with hand-computed literal expectations.
   // Literal checks run 4 units after the edge; the model checks at +5.
   // ------------------------------------------------------------------
   initial begin
      reset          = 1'b0;
      Iwait          = 1'b0;
      Dwait          = 1'b0;
      exe_is_waiting = 1'b0;
      load_use       = 1'b0;
      branch_taken   = 1'b0;
      branch_target  = 64'd0;

      #3;
      checkOutput("reset_stalls",
                  {59'd0, stall_pc, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB}, 64'd0);
      checkOutput("reset_redir", {61'd0, redirect_valid, redir_pending, reset_IF_ID}, 64'd0);

      @(posedge clk);
      #2 reset = 1'b1;

      // Taken branch with no fetch outstanding: immediate redirect
      applyStimulus(0, 0, 0, 0, 1, 64'h8000_0040);
      #2;
      checkOutput("br_now_valid", {63'd0, redirect_valid}, 64'd1);
      checkOutput("br_now_pc", redirect_pc, 64'h8000_0040);
      checkOutput("br_now_resets", {62'd0, reset_IF_ID, reset_ID_EX}, 64'd3);
      applyStimulus(0, 0, 0, 0, 0, 64'd0);
      #2;
      checkOutput("br_now_stays_run", {63'd0, redir_pending}, 64'd0);

      // Taken branch while a fetch is in flight: park it for 3 cycles
      applyStimulus(1, 0, 0, 0, 1, 64'h8000_0100);
      #2;
      checkOutput("br_park_hold_pc", {62'd0, stall_pc, redirect_valid}, 64'd2);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 0, 0, 0, 0, 64'd0);
         #2;
         checkOutput("parked_state", {62'd0, redir_pending, redirect_valid}, 64'd2);
      end
      applyStimulus(0, 0, 0, 0, 0, 64'd0);
      #2;
      checkOutput("park_release_valid", {62'd0, redirect_valid, reset_IF_ID}, 64'd3);
      checkOutput("park_release_pc", redirect_pc, 64'h8000_0100);
      applyStimulus(0, 0, 0, 0, 0, 64'd0);
      #2;
      checkOutput("park_back_to_run", {63'd0, redir_pending}, 64'd0);

      // Dwait dominates branch and load-use; branch re-presented afterwards
      applyStimulus(0, 1, 0, 1, 1, 64'h8000_0200);
      #2;
      checkOutput("dwait_stalls",
                  {59'd0, stall_pc, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB}, 64'h1f);
      checkOutput("dwait_resets_rv",
                  {60'd0, reset_IF_ID, reset_ID_EX, reset_EX_MEM, redirect_valid}, 64'd0);
      applyStimulus(0, 0, 0, 0, 1, 64'h8000_0200);
      #2;
      checkOutput("dwait_after_redirect", redirect_pc, 64'h8000_0200);

      // Multi-cycle EX busy for 4 cycles
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, 1, 0, 0, 64'd0);
         #2;
         checkOutput("exe_wait",
                     {58'd0, stall_pc, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB, reset_EX_MEM},
                     64'b111001);
      end

      // Load-use for one cycle, then free-flowing
      applyStimulus(0, 0, 0, 1, 0, 64'd0);
      #2;
      checkOutput("load_use",
                  {58'd0, stall_pc, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB, reset_ID_EX},
                  64'b110001);
      applyStimulus(0, 0, 0, 0, 0, 64'd0);
      #2;
      checkOutput("load_use_clear",
                  {59'd0, stall_pc, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB}, 64'd0);

      // Parked redirect delayed by Dwait on the cycle the fetch returns
      applyStimulus(1, 0, 0, 0, 1, 64'h8000_0280);
      applyStimulus(0, 1, 0, 0, 0, 64'd0);
      #2;
      checkOutput("park_dwait_delay", {62'd0, redir_pending, redirect_valid}, 64'd2);
      applyStimulus(0, 0, 0, 0, 0, 64'd0);
      #2;
      checkOutput("park_dwait_release", redirect_pc, 64'h8000_0280);

      // Asynchronous reset while parked drops the pending redirect
      applyStimulus(1, 0, 0, 0, 1, 64'h8000_0300);
      applyStimulus(1, 0, 0, 0, 0, 64'd0);
      #1;
      checkOutput("pre_reset_parked", {63'd0, redir_pending}, 64'd1);
      reset = 1'b0;
      #1;
      checkOutput("async_reset_outputs",
                  {57'd0, stall_pc, stall_IF_ID, redirect_valid, redir_pending,
                   reset_IF_ID, reset_ID_EX, reset_EX_MEM}, 64'd0);
      @(posedge clk);
      #2;
      reset = 1'b1;
      Iwait = 1'b0;
      #2;
      checkOutput("no_redirect_after_reset", {62'd0, redirect_valid, redir_pending}, 64'd0);

      // Randomized traffic with occasional reset pulses
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #2;
         reset          = ($urandom_range(0, 149) != 0);
         Iwait          = ($urandom_range(0, 1) == 1);
         Dwait          = ($urandom_range(0, 6) == 0);
         exe_is_waiting = ($urandom_range(0, 6) == 0);
         load_use       = ($urandom_range(0, 4) == 0);
         branch_taken   = ($urandom_range(0, 4) == 0);
         branch_target  = {$urandom, $urandom};
      end

      @(posedge clk);
      #2 reset = 1'b1;
      @(posedge clk);
      #7;
      $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Consumes wait and hazard indications from fetch, decode, execute and memory.
- Drives the per-register hold and reset_t controls for IF/ID, ID/EX, EX/MEM and MEM/WB, plus the PC hold and redirect.
- Holds a branch redirect that arrives while a fetch is still in flight, and squashes the stale fetch when it returns.

Parameters:
- PC_W, 64, PC and redirect target width.
- CNT_W, 32, width of the perf counters (only used with PIPE_CTRL_PERF_EN).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-low.
- Iwait  in  1  fetch memory access outstanding.
- Dwait  in  1  data memory access outstanding in MEM.
- exe_is_waiting  in  1  multi-cycle mul/div busy in EX.
- load_use  in  1  ID instruction needs the result of a load currently in EX.
- branch_taken  in  1  EX resolved a taken branch or jump this cycle.
- branch_target  in  PC_W  target for branch_taken.
- stall_pc  out  1  PC register holds.
- stall_IF_ID  out  1  IF/ID holds.
- stall_ID_EX  out  1  ID/EX reloads its previous contents.
- stall_EX_MEM  out  1  EX/MEM holds.
- stall_MEM_WB  out  1  MEM/WB holds.
- reset_IF_ID  out  reset_t  RESET_RESET inserts a bubble.
- reset_ID_EX  out  reset_t  same, for ID/EX.
- reset_EX_MEM  out  reset_t  same, for EX/MEM.
- redirect_valid  out  1  PC loads redirect_pc this cycle.
- redirect_pc  out  PC_W  redirect target.
- redir_pending  out  1  FSM is in REDIR_PEND.

Behaviour:
- Only the FSM and the pending-target register are flops. All other outputs are combinational from state and inputs, with 0-cycle latency.
- Reset values (reset low, asynchronous):
  - state = RUN, pend_pc = 0.
  - All stall_* = 0, all reset_* = RESET_CONTINUE.
  - redirect_valid = 0, redirect_pc = 0, redir_pending = 0.
- Asserting reset mid-operation drops any pending redirect.
- States:
  - RUN: normal operation.
  - REDIR_PEND: a taken branch was accepted while Iwait=1. pend_pc holds the target.
- Priority in RUN, highest first; only the first matching rule applies:
  1. Dwait=1: all five stalls = 1; all reset_* = CONTINUE; redirect_valid = 0. branch_taken is ignored, because EX is frozen and re-presents it later.
  2. exe_is_waiting=1: stall_pc, stall_IF_ID and stall_ID_EX = 1; reset_EX_MEM = RESET (bubble into MEM); stall_EX_MEM = 0, stall_MEM_WB = 0. branch_taken is ignored.
  3. branch_taken=1:
     - reset_IF_ID = RESET and reset_ID_EX = RESET.
     - If Iwait=0: redirect_valid = 1 and redirect_pc = branch_target; stay in RUN.
     - If Iwait=1: stall_pc = 1, pend_pc <= branch_target, next state REDIR_PEND.
  4. load_use=1: stall_pc = 1, stall_IF_ID = 1, reset_ID_EX = RESET. The load proceeds to MEM.
  5. Iwait=1: stall_pc = 1, reset_IF_ID = RESET.
  6. Otherwise: all stalls = 0, all resets = CONTINUE.
- REDIR_PEND:
  - redir_pending = 1. reset_IF_ID = RESET every cycle, so the stale fetch is squashed.
  - Dwait and exe_is_waiting still apply exactly as in RUN rules 1 and 2.
  - load_use and branch_taken cannot occur here, because ID/EX holds a bubble. If they do assert, they are ignored.
  - While Iwait=1: stall_pc = 1, redirect_valid = 0.
  - First cycle with Iwait=0: redirect_valid = 1, redirect_pc = pend_pc, next state RUN. The returning stale instruction is discarded by reset_IF_ID in that same cycle.
  - If Dwait=1 in that same cycle, the redirect is delayed. Stay in REDIR_PEND until Dwait=0.
- redirect_pc = 0 whenever redirect_valid = 0.
- Invariant: a register never sees stall=1 and reset=RESET together. Stall wins, and reset is forced to CONTINUE.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- When defined, the block adds the following outputs, all CNT_W wide, saturating at all-ones and cleared by reset:
  - perf_dwait_cyc: cycles with rule 1 active.
  - perf_exe_cyc: cycles with rule 2 active.
  - perf_loaduse_cyc: cycles with rule 4 active.
  - perf_flush_cnt: count of accepted taken branches; increments once per branch, including the pending case.
- When undefined, none of these ports or counters exist. Behaviour is otherwise identical.

Test Plan:
- branch_taken=1, branch_target=0x8000_0040, Iwait=0 -> same cycle: redirect_valid=1, redirect_pc=0x8000_0040, reset_IF_ID=RESET, reset_ID_EX=RESET; state stays RUN.
- branch_taken=1 (target 0x8000_0100) with Iwait=1 held for 3 cycles -> redir_pending=1 and redirect_valid=0 for 3 cycles; in the cycle Iwait drops: redirect_valid=1, redirect_pc=0x8000_0100, reset_IF_ID=RESET; next cycle state is RUN.
- Dwait=1 together with branch_taken=1 and load_use=1 -> all stalls=1, all resets=CONTINUE, redirect_valid=0; after Dwait falls, branch_taken re-presented -> redirect occurs.
- exe_is_waiting=1 for 4 cycles -> stall_pc, stall_IF_ID, stall_ID_EX=1 and reset_EX_MEM=RESET each cycle; stall_MEM_WB=0.
- load_use=1 for one cycle -> stall_pc=1, stall_IF_ID=1, reset_ID_EX=RESET; next cycle with load_use=0: all stalls=0.
- reset driven low asynchronously while in REDIR_PEND -> immediately redir_pending=0 and all outputs at reset values; after release, Iwait=0 -> no redirect issued.
